// File: rtl/alu_operand_pkg.sv
// Shared types and constants for the ALU source-A operand stage.
package alu_operand_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int ALU_SRC_FIXED = 4;

  typedef enum logic [1:0] {
    SRC_PC    = 2'd0,
    SRC_OLDPC = 2'd1,
    SRC_A     = 2'd2,
    SRC_IMM   = 2'd3
  } alu_src_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_operand_stage_capture_reg.sv
// Enable register with synchronous active-low clear, used for the OldPC and A holding registers.
module capture_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU source-A select with internal OldPC/A capture and a one-entry valid/ready output slot.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  localparam int EXT_N  = (NUM_SRC > ALU_SRC_FIXED) ? (NUM_SRC - ALU_SRC_FIXED) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       pc,
  input  logic                   pc_capture,
  input  logic [WIDTH-1:0]       rf_rd1,
  input  logic                   a_capture,
  input  logic [WIDTH-1:0]       imm_ext,
  input  logic [EXT_N*WIDTH-1:0] ext_src,
  input  logic [SEL_W-1:0]       src_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   sel_err
);

  logic [WIDTH-1:0] old_pc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;
  logic             accept;
  logic             unused_ext;
  slot_state_e      state_q;
  slot_state_e      state_d;

  // With NUM_SRC=4 the ext_src port is a single slice that no source reads.
  assign unused_ext = ^ext_src;

  capture_reg #(.WIDTH(WIDTH)) u_old_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pc_capture),
    .d       (pc),
    .q       (old_pc_q)
  );

  capture_reg #(.WIDTH(WIDTH)) u_a (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (a_capture),
    .d       (rf_rd1),
    .q       (a_q)
  );

  // Capture registers are read pre-update, so a same-cycle capture is not visible here.
  always_comb begin
    sel_data = '0;
    sel_oob  = 32'(src_sel) >= 32'(NUM_SRC);
    if (32'(src_sel) == 32'(SRC_PC))
      sel_data = pc;
    else if (32'(src_sel) == 32'(SRC_OLDPC))
      sel_data = old_pc_q;
    else if (32'(src_sel) == 32'(SRC_A))
      sel_data = a_q;
    else if (32'(src_sel) == 32'(SRC_IMM))
      sel_data = imm_ext;
    for (int k = ALU_SRC_FIXED; k < NUM_SRC; k++) begin
      if (32'(src_sel) == 32'(k))
        sel_data = ext_src[(k-ALU_SRC_FIXED)*WIDTH +: WIDTH];
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign in_ready  = reset_n && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n)
      state_q <= SLOT_EMPTY;
    else
      state_q <= state_d;
  end

  // Flush beats any same-cycle accept.
  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = SLOT_EMPTY;
    else begin
      case (state_q)
        SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
        SLOT_FULL: begin
          if (accept)
            state_d = SLOT_FULL;
          else if (out_ready)
            state_d = SLOT_EMPTY;
        end
        default: state_d = SLOT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data <= '0;
      sel_err  <= 1'b0;
    end else if (accept && !flush) begin
      out_data <= sel_data;
      sel_err  <= sel_oob;
    end
  end

endmodule
